// File: rtl/fc_link_monitor_pkg.sv
// Shared types and widths for the transceiver link monitor.
package fc_link_monitor_pkg;

    localparam int STATE_W = 2;
    localparam int LOSS_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_DOWN      = 2'd0,
        ST_SYNCING   = 2'd1,
        ST_UP        = 2'd2,
        ST_RESETTING = 2'd3
    } link_state_e;

endpackage

// File: rtl/fc_link_monitor_ch.sv
// One channel of the link monitor: bring-up FSM, lock/timeout/pulse counters, loss counter.
// Loss counting exists only when FC_LINK_MONITOR_STATS_EN is defined.
module fc_link_monitor_ch
    import fc_link_monitor_pkg::*;
#(
    parameter int SYNC_WIDTH         = 4,
    parameter int LOCK_CYCLES        = 1024,
    parameter int TIMEOUT_CYCLES     = 1048576,
    parameter int RESET_PULSE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tx_ready,
    input  logic                  i_rx_ready,
    input  logic [SYNC_WIDTH-1:0] i_sync,
    input  logic                  i_stats_clear,
    output logic                  o_link_up,
    output logic [STATE_W-1:0]    o_state,
    output logic                  o_phy_reset_req,
    output logic [LOSS_W-1:0]     o_loss_count
);

    localparam int LOCK_W  = $clog2(LOCK_CYCLES) + 1;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int PULSE_W = $clog2(RESET_PULSE_CYCLES) + 1;

    localparam logic [LOCK_W-1:0]  LOCK_TERM  = LOCK_W'(LOCK_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_TERM   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_TERM = PULSE_W'(RESET_PULSE_CYCLES);

    link_state_e        r_state;
    logic [LOCK_W-1:0]  r_lock;
    logic [TMO_W-1:0]   r_tmo;
    logic [PULSE_W-1:0] r_pulse;
    logic               r_link_up;
    logic               r_phy_reset_req;

    logic               w_ready;
    logic               w_qual;
    logic               w_loss_event;
    logic [LOCK_W-1:0]  w_lock_inc;
    logic [TMO_W-1:0]   w_tmo_inc;
    logic [PULSE_W-1:0] w_pulse_inc;

    assign w_ready      = i_tx_ready & i_rx_ready;
    assign w_qual       = w_ready & (&i_sync);
    assign w_loss_event = (r_state == ST_UP) & ~w_qual;
    assign w_lock_inc   = r_lock + LOCK_W'(1);
    assign w_tmo_inc    = r_tmo + TMO_W'(1);
    assign w_pulse_inc  = r_pulse + PULSE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_DOWN;
            r_lock          <= '0;
            r_tmo           <= '0;
            r_pulse         <= '0;
            r_link_up       <= 1'b0;
            r_phy_reset_req <= 1'b0;
        end else begin
            case (r_state)
                ST_DOWN: begin
                    if (w_ready) begin
                        r_state <= ST_SYNCING;
                        r_lock  <= '0;
                        r_tmo   <= '0;
                    end
                end
                ST_SYNCING: begin
                    if (!w_ready) begin
                        r_state <= ST_DOWN;
                    end else begin
                        r_lock <= w_qual ? w_lock_inc : '0;
                        r_tmo  <= w_tmo_inc;
                        // Lock completing on the timeout edge still wins.
                        if (w_qual && (w_lock_inc == LOCK_TERM)) begin
                            r_state   <= ST_UP;
                            r_link_up <= 1'b1;
                        end else if (w_tmo_inc == TMO_TERM) begin
                            r_state         <= ST_RESETTING;
                            r_phy_reset_req <= 1'b1;
                            r_pulse         <= '0;
                        end
                    end
                end
                ST_UP: begin
                    if (!w_qual) begin
                        r_state   <= ST_DOWN;
                        r_link_up <= 1'b0;
                    end
                end
                ST_RESETTING: begin
                    r_pulse <= w_pulse_inc;
                    if (w_pulse_inc == PULSE_TERM) begin
                        r_state         <= ST_DOWN;
                        r_phy_reset_req <= 1'b0;
                    end
                end
                default: r_state <= ST_DOWN;
            endcase
        end
    end

    assign o_link_up       = r_link_up;
    assign o_state         = r_state;
    assign o_phy_reset_req = r_phy_reset_req;

`ifdef FC_LINK_MONITOR_STATS_EN
    logic [LOSS_W-1:0] r_loss;
    logic [LOSS_W-1:0] w_loss_base;

    // Clear first, so a loss on the clearing cycle leaves the count at 1.
    assign w_loss_base = i_stats_clear ? '0 : r_loss;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss <= '0;
        end else if (w_loss_event && (w_loss_base != '1)) begin
            r_loss <= w_loss_base + LOSS_W'(1);
        end else begin
            r_loss <= w_loss_base;
        end
    end

    assign o_loss_count = r_loss;
`else
    logic w_unused_stats;
    assign w_unused_stats = i_stats_clear ^ w_loss_event;
    assign o_loss_count   = '0;
`endif

endmodule

// File: rtl/fc_link_monitor.sv
// Multi-channel transceiver link monitor: per-channel FSM instances plus all_up.
// Optional loss statistics enabled by FC_LINK_MONITOR_STATS_EN.
module fc_link_monitor
    import fc_link_monitor_pkg::*;
#(
    parameter int CHANNELS           = 1,
    parameter int SYNC_WIDTH         = 4,
    parameter int LOCK_CYCLES        = 1024,
    parameter int TIMEOUT_CYCLES     = 1048576,
    parameter int RESET_PULSE_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            tx_ready,
    input  logic [CHANNELS-1:0]            rx_ready,
    input  logic [CHANNELS*SYNC_WIDTH-1:0] rx_syncstatus,
    input  logic                           stats_clear,
    output logic [CHANNELS-1:0]            link_up,
    output logic                           all_up,
    output logic [CHANNELS*STATE_W-1:0]    link_state,
    output logic [CHANNELS-1:0]            phy_reset_req,
    output logic [CHANNELS*LOSS_W-1:0]     loss_count
);

    logic r_all_up;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            fc_link_monitor_ch #(
                .SYNC_WIDTH        (SYNC_WIDTH),
                .LOCK_CYCLES       (LOCK_CYCLES),
                .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
                .RESET_PULSE_CYCLES(RESET_PULSE_CYCLES)
            ) u_ch (
                .clk            (clk),
                .reset          (reset),
                .i_tx_ready     (tx_ready[gi]),
                .i_rx_ready     (rx_ready[gi]),
                .i_sync         (rx_syncstatus[gi*SYNC_WIDTH +: SYNC_WIDTH]),
                .i_stats_clear  (stats_clear),
                .o_link_up      (link_up[gi]),
                .o_state        (link_state[gi*STATE_W +: STATE_W]),
                .o_phy_reset_req(phy_reset_req[gi]),
                .o_loss_count   (loss_count[gi*LOSS_W +: LOSS_W])
            );
        end
    endgenerate

    // Built from the registered link_up bits, so it trails them by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_all_up <= 1'b0;
        end else begin
            r_all_up <= &link_up;
        end
    end

    assign all_up = r_all_up;

endmodule

// File: tb/tb_fc_link_monitor.sv
// Bench for fc_link_monitor: directed bring-up/loss/timeout/reset scenarios, then random traffic,
// all checked every cycle against a behavioural channel model.
module tb_fc_link_monitor;

    localparam int CH    = 2;
    localparam int SW    = 4;
    localparam int LOCK  = 8;
    localparam int TMO   = 32;
    localparam int PULSE = 4;
`ifdef FC_LINK_MONITOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int LOSS1 = STATS ? 1 : 0;

    logic              clk;
    logic              rst;
    logic [CH-1:0]     tx;
    logic [CH-1:0]     rx;
    logic [CH*SW-1:0]  sync;
    logic              clr;
    logic [CH-1:0]     link_up;
    logic              all_up;
    logic [CH*2-1:0]   link_state;
    logic [CH-1:0]     phy_reset_req;
    logic [CH*16-1:0]  loss_count;

    fc_link_monitor #(
        .CHANNELS          (CH),
        .SYNC_WIDTH        (SW),
        .LOCK_CYCLES       (LOCK),
        .TIMEOUT_CYCLES    (TMO),
        .RESET_PULSE_CYCLES(PULSE)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .tx_ready     (tx),
        .rx_ready     (rx),
        .rx_syncstatus(sync),
        .stats_clear  (clr),
        .link_up      (link_up),
        .all_up       (all_up),
        .link_state   (link_state),
        .phy_reset_req(phy_reset_req),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 down, 1 syncing, 2 up, 3 resetting. run = consecutive qualified
    // cycles while syncing, age = cycles spent syncing, left = pulse cycles remaining.
    int m_st[CH];
    int m_run[CH];
    int m_age[CH];
    int m_left[CH];
    int m_loss[CH];
    int m_all_up;
    bit started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_st[c] = 0; m_run[c] = 0; m_age[c] = 0; m_left[c] = 0; m_loss[c] = 0;
            end
            m_all_up = 0;
        end else begin
            m_all_up = 1;
            for (int c = 0; c < CH; c++)
                if (m_st[c] != 2) m_all_up = 0;
            for (int c = 0; c < CH; c++) begin
                bit rdy;
                bit q;
                bit ev;
                rdy = tx[c] && rx[c];
                q   = rdy && (sync[c*SW +: SW] == {SW{1'b1}});
                ev  = 1'b0;
                case (m_st[c])
                    0: if (rdy) begin m_st[c] = 1; m_run[c] = 0; m_age[c] = 0; end
                    1: begin
                        if (!rdy) m_st[c] = 0;
                        else begin
                            m_age[c]++;
                            m_run[c] = q ? m_run[c] + 1 : 0;
                            if (m_run[c] == LOCK) m_st[c] = 2;
                            else if (m_age[c] == TMO) begin m_st[c] = 3; m_left[c] = PULSE; end
                        end
                    end
                    2: if (!q) begin m_st[c] = 0; ev = 1'b1; end
                    default: begin
                        m_left[c]--;
                        if (m_left[c] == 0) m_st[c] = 0;
                    end
                endcase
                if (STATS) begin
                    if (clr) m_loss[c] = 0;
                    if (ev && m_loss[c] < 65535) m_loss[c]++;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < CH; c++) begin
                check($sformatf("link_up[%0d]", c), int'(link_up[c]), int'(m_st[c] == 2));
                check($sformatf("link_state[%0d]", c), int'(link_state[c*2 +: 2]), m_st[c]);
                check($sformatf("phy_reset_req[%0d]", c), int'(phy_reset_req[c]), int'(m_st[c] == 3));
                check($sformatf("loss_count[%0d]", c), int'(loss_count[c*16 +: 16]), m_loss[c]);
            end
            check("all_up", int'(all_up), m_all_up);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tx = '0; rx = '0; sync = '0; clr = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx = '0; rx = '0; sync = '0; clr = 1'b0;
        tick(3);
        rst = 1'b0;
        check("rst_state", int'(link_state), 0);
        check("rst_all_up", int'(all_up), 0);
        check("rst_loss", int'(loss_count[15:0]), 0);
        check("rst_req", int'(phy_reset_req), 0);
        $display("txn reset: state=%0h all_up=%0d", link_state, all_up);

        // Plain bring-up of channel 0.
        tx = 2'b01; rx = 2'b01; sync = 8'h0F;
        tick(1);  check("A_sync", int'(link_state[1:0]), 1);
        tick(7);  check("A_still_sync", int'(link_state[1:0]), 1);
        tick(1);  check("A_up", int'(link_state[1:0]), 2);
        check("A_link_up", int'(link_up), 1);
        check("A_all_up", int'(all_up), 0);
        $display("txn bringup: state=%0h link_up=%0b all_up=%0d", link_state, link_up, all_up);

        // One lane glitch restarts the lock count.
        do_reset();
        tx = 2'b01; rx = 2'b01; sync = 8'h0F;
        tick(8);  sync = 8'h07;
        tick(1);  sync = 8'h0F;
        tick(7);  check("B_not_yet", int'(link_state[1:0]), 1);
        tick(1);  check("B_up", int'(link_state[1:0]), 2);
        $display("txn relock: state=%0h", link_state);

        // Channel 1 never syncs: timeout and reset pulse.
        do_reset();
        tx = 2'b10; rx = 2'b10; sync = 8'h00;
        tick(32); check("C_sync", int'(link_state[3:2]), 1);
        check("C_req_lo", int'(phy_reset_req), 0);
        tick(1);  check("C_resetting", int'(link_state[3:2]), 3);
        check("C_req_hi", int'(phy_reset_req), 2);
        tick(3);  check("C_req_hold", int'(phy_reset_req), 2);
        tick(1);  check("C_down", int'(link_state[3:2]), 0);
        check("C_req_end", int'(phy_reset_req), 0);
        tx = '0; rx = '0;
        $display("txn timeout: state=%0h req=%0b", link_state, phy_reset_req);

        // Loss on an up link, then a loss coincident with stats_clear.
        do_reset();
        tx = 2'b11; rx = 2'b11; sync = 8'hFF;
        tick(10); check("D_all_up", int'(all_up), 1);
        sync = 8'hFE;
        tick(1);  check("D_ch0_down", int'(link_state[1:0]), 0);
        check("D_loss1", int'(loss_count[15:0]), LOSS1);
        check("D_all_up_lag", int'(all_up), 1);
        sync = 8'hFF;
        tick(1);  check("D_all_up_fall", int'(all_up), 0);
        tick(8);  check("D_ch0_reup", int'(link_state[1:0]), 2);
        sync = 8'hFE; clr = 1'b1;
        tick(1);  check("D_clr_loss", int'(loss_count[15:0]), LOSS1);
        clr = 1'b0; sync = 8'hFF;
        tick(1);
        $display("txn loss: loss0=%0d all_up=%0d", loss_count[15:0], all_up);

        // Reset in the middle of the PHY reset pulse.
        do_reset();
        tx = 2'b10; rx = 2'b10; sync = 8'h00;
        tick(33); check("E_resetting", int'(link_state[3:2]), 3);
        tick(1);  check("E_req_mid", int'(phy_reset_req), 2);
        rst = 1'b1;
        tick(1);  check("E_state", int'(link_state), 0);
        check("E_req", int'(phy_reset_req), 0);
        check("E_link_up", int'(link_up), 0);
        rst = 1'b0; tx = '0; rx = '0;
        $display("txn midpulse_reset: state=%0h req=%0b", link_state, phy_reset_req);

        // Random traffic with varying sync quality.
        for (int b = 0; b < 12; b++) begin
            int bias;
            case (b % 3)
                0: bias = 3;
                1: bias = 40;
                default: bias = 300;
            endcase
            for (int k = 0; k < 400; k++) begin
                for (int c = 0; c < CH; c++) begin
                    tx[c] = ($urandom_range(0, 63) != 0);
                    rx[c] = ($urandom_range(0, 63) != 0);
                    for (int l = 0; l < SW; l++)
                        sync[c*SW + l] = ($urandom_range(0, bias) != 0);
                end
                clr = ($urandom_range(0, 99) == 0);
                rst = ($urandom_range(0, 499) == 0);
                tick(1);
            end
            $display("txn random burst %0d bias=%0d: loss0=%0d loss1=%0d checks=%0d",
                     b, bias, loss_count[15:0], loss_count[31:16], total);
        end
        rst = 1'b0; clr = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
